// File: rtl/booth_mul_pkg.sv
// Shared widths, Booth digit encoding and carry-save helpers for booth_mul.
package booth_mul_pkg;

  localparam int WIDTH   = 32;
  localparam int PROD_W  = 2 * WIDTH;
  localparam int NUM_PP  = WIDTH / 2 + 1;
  localparam int LATENCY = 4;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_e;

  // Radix-4 recoding of (b[2i+1], b[2i], b[2i-1]).
  function automatic booth_digit_e booth_digit(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

  function automatic logic [PROD_W-1:0] csa_sum(input logic [PROD_W-1:0] x,
                                                input logic [PROD_W-1:0] y,
                                                input logic [PROD_W-1:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [PROD_W-1:0] csa_carry(input logic [PROD_W-1:0] x,
                                                  input logic [PROD_W-1:0] y,
                                                  input logic [PROD_W-1:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

endpackage

// File: rtl/booth_mul_pp.sv
// One Booth partial product: the selected multiple of the multiplicand, one's-complemented
// when negative and shifted into place; neg_o is the +1 that completes the negation.
module booth_pp_gen
  import booth_mul_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  logic [WIDTH-1:0]  multiplicand_i,
  input  booth_digit_e      digit_i,
  output logic [PROD_W-1:0] pp_o,
  output logic              neg_o
);

  logic [PROD_W-1:0] ext;
  logic [PROD_W-1:0] mag;

  // The +1 lands at bit SHIFT because the low SHIFT bits of the shifted complement are zero.
  always_comb begin
    ext = {{(PROD_W-WIDTH){multiplicand_i[WIDTH-1]}}, multiplicand_i};
    case (digit_i)
      POS1, NEG1: mag = ext;
      POS2, NEG2: mag = ext << 1;
      default:    mag = '0;
    endcase
    neg_o = (digit_i == NEG1) || (digit_i == NEG2);
    pp_o  = (neg_o ? ~mag : mag) << SHIFT;
  end

endmodule

// File: rtl/booth_mul.sv
// Four-stage pipelined signed multiplier (radix-4 Booth, 3:2 carry-save tree, final adder).
// Defining BOOTH_MUL_ASSERT_EN compiles in simulation-only protocol and result checks.
module booth_mul
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data1,
  input  logic [WIDTH-1:0]     data2,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   res
);

  logic                stall;
  logic [WIDTH+2:0]    b_pad;
  booth_digit_e        dig_d [NUM_PP];
  booth_digit_e        dig_q [NUM_PP];
  logic [WIDTH-1:0]    a_q;
  logic                v1_q, v2_q, v3_q, v4_q;
  logic [PROD_W-1:0]   pp [NUM_PP];
  logic [NUM_PP-1:0]   neg;
  logic [PROD_W-1:0]   l0 [NUM_PP+1];
  logic [PROD_W-1:0]   l1 [12];
  logic [PROD_W-1:0]   l2_d [8];
  logic [PROD_W-1:0]   l2_q [8];
  logic [PROD_W-1:0]   l3 [6];
  logic [PROD_W-1:0]   l4 [4];
  logic [PROD_W-1:0]   l5 [3];
  logic [PROD_W-1:0]   sum_d, carry_d, sum_q, carry_q;
  logic [PROD_W-1:0]   res_q;

  assign stall   = v4_q && !ready_i;
  assign ready_o = !stall;
  assign valid_o = v4_q;
  assign res     = res_q;

  // data2 sign-extended to 34 bits with the implicit b[-1]=0 below bit 0.
  assign b_pad = {data2[WIDTH-1], data2[WIDTH-1], data2, 1'b0};

  always_comb begin
    for (int i = 0; i < NUM_PP; i++) dig_d[i] = booth_digit(b_pad[2*i +: 3]);
  end

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen #(.SHIFT(2*i)) u_pp (
      .multiplicand_i (a_q),
      .digit_i        (dig_q[i]),
      .pp_o           (pp[i]),
      .neg_o          (neg[i])
    );
  end

  // Negation correction bits never collide, so they share one extra row.
  always_comb begin
    for (int i = 0; i < NUM_PP; i++) l0[i] = pp[i];
    l0[NUM_PP] = '0;
    for (int i = 0; i < NUM_PP; i++) l0[NUM_PP][2*i] = neg[i];
  end

  for (genvar g = 0; g < 6; g++) begin : g_l1
    assign l1[2*g]   = csa_sum  (l0[3*g], l0[3*g+1], l0[3*g+2]);
    assign l1[2*g+1] = csa_carry(l0[3*g], l0[3*g+1], l0[3*g+2]);
  end

  for (genvar g = 0; g < 4; g++) begin : g_l2
    assign l2_d[2*g]   = csa_sum  (l1[3*g], l1[3*g+1], l1[3*g+2]);
    assign l2_d[2*g+1] = csa_carry(l1[3*g], l1[3*g+1], l1[3*g+2]);
  end

  // Second half of the tree runs between the S2 and S3 registers: 8 -> 6 -> 4 -> 3 -> 2 rows.
  for (genvar g = 0; g < 2; g++) begin : g_l3
    assign l3[2*g]   = csa_sum  (l2_q[3*g], l2_q[3*g+1], l2_q[3*g+2]);
    assign l3[2*g+1] = csa_carry(l2_q[3*g], l2_q[3*g+1], l2_q[3*g+2]);
  end
  assign l3[4] = l2_q[6];
  assign l3[5] = l2_q[7];

  for (genvar g = 0; g < 2; g++) begin : g_l4
    assign l4[2*g]   = csa_sum  (l3[3*g], l3[3*g+1], l3[3*g+2]);
    assign l4[2*g+1] = csa_carry(l3[3*g], l3[3*g+1], l3[3*g+2]);
  end

  assign l5[0]   = csa_sum  (l4[0], l4[1], l4[2]);
  assign l5[1]   = csa_carry(l4[0], l4[1], l4[2]);
  assign l5[2]   = l4[3];
  assign sum_d   = csa_sum  (l5[0], l5[1], l5[2]);
  assign carry_d = csa_carry(l5[0], l5[1], l5[2]);

  // A single stall freezes every stage; only valid bits and res are cleared on reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      v4_q  <= 1'b0;
      res_q <= '0;
    end else if (!stall) begin
      v1_q    <= valid_i;
      a_q     <= data1;
      dig_q   <= dig_d;
      v2_q    <= v1_q;
      l2_q    <= l2_d;
      v3_q    <= v2_q;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      v4_q    <= v3_q;
      res_q   <= sum_q + carry_q;
    end
  end

`ifdef BOOTH_MUL_ASSERT_EN
  logic                     chk_rst_seen_q = 1'b0;
  logic                     chk_stall_q    = 1'b0;
  logic [PROD_W-1:0]        chk_res_q;
  logic signed [PROD_W-1:0] chk_exp_q [$];

  always @(posedge clk) begin
    if (!rst_n && chk_rst_seen_q && $isunknown(valid_o))
      $error("booth_mul: valid_o is X after reset");
    if (!rst_n && chk_stall_q && res != chk_res_q)
      $error("booth_mul: res changed while stalled");
    if (rst_n) begin
      chk_exp_q.delete();
    end else begin
      if (valid_o && ready_i) begin
        if (chk_exp_q.size() == 0)
          $error("booth_mul: product emitted with nothing in flight");
        else if (res != chk_exp_q.pop_front())
          $error("booth_mul: product mismatch");
      end
      if (valid_i && ready_o)
        chk_exp_q.push_back(PROD_W'($signed(data1)) * PROD_W'($signed(data2)));
    end
    chk_rst_seen_q <= chk_rst_seen_q || rst_n;
    chk_stall_q    <= !rst_n && stall;
    chk_res_q      <= res;
  end
`endif

endmodule

// File: tb/tb_booth_mul.sv
// Directed and random checks for booth_mul: latency, corner products, backpressure,
// bubbles and mid-stream reset.
module tb_booth_mul;

  localparam int LAT = 4;
  localparam int NV  = 18;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data1, data2;
  logic        valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [63:0] res;

  int compared   = 0;
  int mismatched = 0;
  vec_t vecs [NV];
  logic [63:0] rexp [$];

  booth_mul #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data1   (data1),
    .data2   (data2),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res     (res)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic rdy);
    valid_i = v;
    data1   = a;
    data2   = b;
    ready_i = rdy;
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
    vecs[1]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[2]  = '{32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vecs[4]  = '{32'h00000000, 32'h12345678, 64'h0000000000000000};
    vecs[5]  = '{32'h12345678, 32'h00000000, 64'h0000000000000000};
    vecs[6]  = '{32'h00000003, 32'h00000005, 64'h000000000000000F};
    vecs[7]  = '{32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFFFFFFFFF1};
    vecs[8]  = '{32'h00000007, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFF9};
    vecs[9]  = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[10] = '{32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000};
    vecs[11] = '{32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000};
    vecs[12] = '{32'h00000002, 32'h40000000, 64'h0000000080000000};
    vecs[13] = '{32'h55555555, 32'h00000003, 64'h00000000FFFFFFFF};
    vecs[14] = '{32'hAAAAAAAA, 32'h00000003, 64'hFFFFFFFEFFFFFFFE};
    vecs[15] = '{32'h12345678, 32'h00000010, 64'h0000000123456780};
    vecs[16] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 64'hFFFFFFFF80000001};
    vecs[17] = '{32'h0000FFFF, 32'h0000FFFF, 64'h00000000FFFE0001};

    rst_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("reset valid_o", valid_o, 64'd0);
    checkOutput("reset ready_o", ready_o, 64'd1);
    checkOutput("reset res", res, 64'd0);
    rst_n = 1'b0;
    idle(2);

    // Back-to-back corner vectors; output c shows the pair driven LAT cycles earlier.
    for (int c = 0; c < NV + LAT; c++) begin
      if (c >= LAT) begin
        checkOutput($sformatf("vec%0d valid_o", c - LAT), valid_o, 64'd1);
        checkOutput($sformatf("vec%0d res", c - LAT), res, vecs[c-LAT].prod);
      end else begin
        checkOutput($sformatf("latency valid_o c%0d", c), valid_o, 64'd0);
      end
      if (c < NV) applyStimulus(1'b1, vecs[c].a, vecs[c].b, 1'b1);
      else        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      @(negedge clk);
    end
    idle(6);

    // Random signed stream at full throughput.
    for (int c = 0; c < 10000 + LAT; c++) begin
      logic [31:0] ra, rb;
      if (c >= LAT) begin
        logic [63:0] e;
        e = rexp.pop_front();
        checkOutput("random valid_o", valid_o, 64'd1);
        checkOutput($sformatf("random res c%0d", c), res, e);
      end
      if (c < 10000) begin
        ra = $urandom();
        rb = $urandom();
        rexp.push_back(64'($signed(ra)) * 64'($signed(rb)));
        applyStimulus(1'b1, ra, rb, 1'b1);
      end else begin
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      end
      @(negedge clk);
    end
    idle(6);

    // Backpressure: k*k for k=1..8, ready_i low for cycles 5..7 while 2*2 is on res.
    begin
      int idx, got, extra;
      logic rdy;
      idx = 0;
      got = 0;
      for (int c = 0; c < 40 && got < 8; c++) begin
        rdy = !(c >= 5 && c <= 7);
        if (idx < 8) applyStimulus(1'b1, 32'(idx + 1), 32'(idx + 1), rdy);
        else         applyStimulus(1'b0, 32'd0, 32'd0, rdy);
        #1;
        if (c >= 5 && c <= 7) begin
          checkOutput($sformatf("bp ready_o c%0d", c), ready_o, 64'd0);
          checkOutput($sformatf("bp valid_o c%0d", c), valid_o, 64'd1);
          checkOutput($sformatf("bp res frozen c%0d", c), res, 64'd4);
        end
        if (valid_o && ready_i) begin
          checkOutput($sformatf("bp order %0d", got), res, 64'((got + 1) * (got + 1)));
          got++;
        end
        if (valid_i && ready_o) idx++;
        @(negedge clk);
      end
      checkOutput("bp product count", 64'(got), 64'd8);
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      extra = 0;
      for (int c = 0; c < 8; c++) begin
        if (valid_o) extra++;
        @(negedge clk);
      end
      checkOutput("bp no duplicate", 64'(extra), 64'd0);
    end
    idle(4);

    // Bubbles: valid_i 1,0,1,0 must reappear as valid_o 1,0,1,0 four cycles later.
    for (int c = 0; c < 8; c++) begin
      if (c == 0)      applyStimulus(1'b1, 32'd5, 32'd6, 1'b1);
      else if (c == 2) applyStimulus(1'b1, 32'd7, 32'd8, 1'b1);
      else if (c < 4)  applyStimulus(1'b0, 32'hDEADBEEF, 32'h01234567, 1'b1);
      else             applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      checkOutput($sformatf("bubble ready_o c%0d", c), ready_o, 64'd1);
      if (c >= 4) checkOutput($sformatf("bubble valid_o c%0d", c), valid_o, 64'(c % 2 == 0));
      if (c == 4) checkOutput("bubble res 5x6", res, 64'd30);
      if (c == 6) checkOutput("bubble res 7x8", res, 64'd56);
      @(negedge clk);
    end
    idle(4);

    // Reset with three products in flight.
    begin
      int stale;
      for (int c = 0; c < 3; c++) begin
        applyStimulus(1'b1, 32'(9 + c), 32'(9 + c), 1'b1);
        @(negedge clk);
      end
      applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midrst valid_o", valid_o, 64'd0);
      checkOutput("midrst res", res, 64'd0);
      checkOutput("midrst ready_o", ready_o, 64'd1);
      rst_n = 1'b0;
      stale = 0;
      for (int c = 0; c < 10; c++) begin
        if (valid_o) stale++;
        @(negedge clk);
      end
      checkOutput("midrst no stale product", 64'(stale), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
